if_id_elastic: RTL
==================

Name: if_id_elastic

Overview:
- Next-generation IF/ID pipeline register. It replaces the stall/flush-only register with an elastic valid/ready stage backed by a 2-entry skid buffer.
- Fetch can push one beat per cycle while decode back-pressures. No ready signal passes combinationally from ID to IF.
- Flush and reset insert a canonical NOP bubble instead of undefined data.
- A saturating bubble counter gives decode-starvation visibility for performance tuning.

Parameters:
- DATA_WIDTH, 32: width of PC, PC+4 and instruction fields.
- NOP_INSTR, 32'h0000_0013: bubble instruction (addi x0,x0,0). Width is DATA_WIDTH.
- CNT_WIDTH, 16: width of the bubble-cycle counter.

Ports:
- clk  in  1  single clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_flush_ID  in  1  kill all buffered beats (branch/jump redirect)
- i_valid_IF  in  1  fetch presents a beat
- o_ready_IF  out  1  stage can accept a beat this cycle
- i_pc_IF  in  DATA_WIDTH  fetch PC
- i_pcplus4_IF  in  DATA_WIDTH  fetch PC+4
- i_instr_IF  in  DATA_WIDTH  fetched instruction
- i_fault_IF  in  1  instruction-access fault tag for this beat
- o_valid_ID  out  1  head beat valid toward decode
- i_ready_ID  in  1  decode consumes the head beat (replaces stall; stall = !i_ready_ID)
- o_pc_ID  out  DATA_WIDTH  head PC
- o_pcplus4_ID  out  DATA_WIDTH  head PC+4
- o_instr_ID  out  DATA_WIDTH  head instruction
- o_fault_ID  out  1  head fault tag
- o_bubble_cnt  out  CNT_WIDTH  saturating count of starved decode cycles

Behaviour:
- Storage: a head entry (drives outputs) and a skid entry. Each entry holds pc, pcplus4, instr and fault.
- Occupancy state: EMPTY, ONE, TWO.
- Handshake terms:
  - accept = i_valid_IF & o_ready_IF
  - consume = o_valid_ID & i_ready_ID
- o_ready_IF = (state != TWO). It is decoded from the state register only and has no combinational dependence on i_ready_ID.
- o_valid_ID = (state != EMPTY).
- Transitions (all registered):
  - EMPTY: accept -> ONE, head <= input.
  - ONE, accept & consume -> ONE, head <= input.
  - ONE, accept & !consume -> TWO, skid <= input.
  - ONE, !accept & consume -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: accept is impossible. consume -> ONE, head <= skid. Otherwise hold.
- Ordering is strict FIFO. The skid beat is always younger than the head beat.
- Latency: 1 cycle from accept into EMPTY to o_valid_ID=1. Sustained throughput is 1 beat/cycle while i_ready_ID=1.
- Bubble payload: whenever head becomes empty (reset, flush, ONE->EMPTY), the head entry is loaded with:
  - o_instr_ID = NOP_INSTR
  - o_pc_ID = 0
  - o_pcplus4_ID = 0
  - o_fault_ID = 0
  - Outputs are never X.
- Flush: i_flush_ID=1 forces state to EMPTY and the head to the bubble payload.
  - Any beat offered in the same cycle is dropped, even if o_ready_IF=1.
  - Any consume in that cycle still counts as taken by decode.
  - o_ready_IF=1 on the next cycle.
- Priority: i_rst > i_flush_ID > handshake.
- Reset values:
  - state EMPTY, o_valid_ID=0, o_ready_IF=1.
  - Head = bubble payload. Skid = 0.
  - o_bubble_cnt=0.
- Reset mid-operation discards both entries identically to flush and also clears the counter.
- Bubble counter:
  - Increments when i_ready_ID=1 & o_valid_ID=0 & !i_flush_ID.
  - Saturates at all-ones with no wrap.
  - Cleared only by i_rst.
- Skid data is written only on the ONE->TWO transition. Head data is written only on an accept into head, a skid->head move, or a bubble load.

Decomposition:
- Shared package osiris_pkg holds:
  - localparam NOP_INSTR_DEFAULT = 32'h0000_0013
  - typedef if_id_beat_t (packed struct: pc, pcplus4, instr, fault)
  - enum if_id_occ_e {EMPTY, ONE, TWO}
- One natural sub-module: skid_buffer. It is a generic 2-entry valid/ready buffer parametrised on payload width.
- if_id_elastic instantiates skid_buffer and adds flush, the bubble payload and the counter.

Test Plan:
- Reset, then i_valid_IF=1 with pc=0x100, instr=0x00500093 and i_ready_ID=1 -> next cycle o_valid_ID=1, o_pc_ID=0x100, o_pcplus4_ID=0x104. Back-to-back beats stream at one per cycle.
- Back-pressure:
  - Push pc 0x200 and pc 0x204 with i_ready_ID=0 -> state TWO, o_ready_IF=0, head=0x200.
  - Raise i_ready_ID -> 0x200 then 0x204 appear in order, and o_ready_IF returns to 1 one cycle after the first consume.
- Flush in TWO with i_valid_IF=1 (pc 0x208) -> next cycle o_valid_ID=0, o_instr_ID=0x00000013, o_pc_ID=0. Beat 0x208 is never emitted.
- Simultaneous accept and consume in ONE (head 0x300, input 0x304) -> head becomes 0x304, state stays ONE, skid is untouched.
- Bubble counter:
  - 5 cycles of i_valid_IF=0 with i_ready_ID=1 -> o_bubble_cnt=5.
  - With CNT_WIDTH=3 and 10 such cycles -> o_bubble_cnt=7 (saturated).
- i_rst asserted in TWO while i_flush_ID=1 -> next cycle state EMPTY, counter 0, o_ready_IF=1, outputs show the bubble payload.

Source files
------------

// File: rtl/osiris_pkg.sv
// Shared types and constants for the Osiris front-end pipeline registers.
//
// Contents:
//   NOP_INSTR_DEFAULT : canonical bubble instruction (addi x0,x0,0)
//   if_id_beat_t      : one IF->ID beat (pc, pcplus4, instr, fault) for the
//                       default 32-bit datapath
//   if_id_occ_e       : occupancy of the 2-entry IF/ID buffer
//   head_src_e        : source selected when the head entry is written
package osiris_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] instr;
    logic        fault;
  } if_id_beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } if_id_occ_e;

  typedef enum logic [1:0] {
    HEAD_IN     = 2'd0,
    HEAD_SKID   = 2'd1,
    HEAD_BUBBLE = 2'd2
  } head_src_e;

endpackage

// File: rtl/if_id_elastic_skid_buffer.sv
// skid_buffer: generic 2-entry valid/ready buffer with a registered ready.
//
// The head entry always drives pop_data. When the buffer drains (or on
// reset/flush) the head is loaded with the BUBBLE constant, so pop_data is
// never undefined. push_ready is decoded from the occupancy register only,
// so there is no combinational path from pop_ready to push_ready.
//
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (head <= BUBBLE, skid <= 0)
//   flush      : drop both entries and any beat offered this cycle
//   push_valid : upstream beat valid
//   push_ready : buffer can accept a beat this cycle
//   push_data  : upstream payload
//   pop_valid  : head entry valid
//   pop_ready  : downstream takes the head entry
//   pop_data   : head payload
module skid_buffer
  import osiris_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data
);

  if_id_occ_e       state_reg;
  if_id_occ_e       state_next;
  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] skid_reg;
  logic [WIDTH-1:0] head_next;
  logic             head_we;
  head_src_e        head_src;
  logic             skid_we;
  logic             accept;
  logic             consume;

  assign push_ready = (state_reg != TWO);
  assign pop_valid  = (state_reg != EMPTY);
  assign pop_data   = head_reg;

  assign accept  = push_valid & push_ready;
  assign consume = pop_valid & pop_ready;

  // Next-state and data-enable decode.
  always_comb begin
    state_next = state_reg;
    head_we    = 1'b0;
    head_src   = HEAD_IN;
    skid_we    = 1'b0;

    if (flush) begin
      // Flush wins over the handshake: the offered beat is dropped, and a
      // concurrent consume has already been seen by the downstream side.
      state_next = EMPTY;
      head_we    = 1'b1;
      head_src   = HEAD_BUBBLE;
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            head_we    = 1'b1;
            head_src   = HEAD_IN;
          end
        end
        ONE: begin
          if (accept && consume) begin
            head_we  = 1'b1;
            head_src = HEAD_IN;
          end else if (accept) begin
            state_next = TWO;
            skid_we    = 1'b1;
          end else if (consume) begin
            state_next = EMPTY;
            head_we    = 1'b1;
            head_src   = HEAD_BUBBLE;
          end
        end
        TWO: begin
          // push_ready is low here, so only a consume can move the state.
          if (consume) begin
            state_next = ONE;
            head_we    = 1'b1;
            head_src   = HEAD_SKID;
          end
        end
        default: begin
          state_next = EMPTY;
          head_we    = 1'b1;
          head_src   = HEAD_BUBBLE;
        end
      endcase
    end
  end

  always_comb begin
    head_next = BUBBLE;
    unique case (head_src)
      HEAD_IN:     head_next = push_data;
      HEAD_SKID:   head_next = skid_reg;
      HEAD_BUBBLE: head_next = BUBBLE;
      default:     head_next = BUBBLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg <= BUBBLE;
    end else if (head_we) begin
      head_reg <= head_next;
    end
  end

  // The skid entry is only written when the buffer goes from one to two
  // beats; a flush leaves it alone since it becomes unreachable anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_reg <= '0;
    end else if (skid_we) begin
      skid_reg <= push_data;
    end
  end

endmodule

// File: rtl/if_id_elastic.sv
// if_id_elastic: elastic IF/ID pipeline register.
//
// Wraps a 2-entry skid buffer carrying {pc, pcplus4, instr, fault}. Reset,
// flush and drain load the head with a NOP bubble (pc=0, pcplus4=0,
// instr=NOP_INSTR, fault=0). A saturating counter records cycles in which
// decode was ready but had nothing to take.
//
// Ports:
//   clk          : clock, rising edge
//   i_rst        : synchronous active-high reset (also clears the counter)
//   i_flush_ID   : discard all buffered beats and the beat offered this cycle
//   i_valid_IF   : fetch beat valid
//   o_ready_IF   : stage can accept a beat (registered, no path from ID)
//   i_pc_IF      : fetch PC
//   i_pcplus4_IF : fetch PC+4
//   i_instr_IF   : fetched instruction
//   i_fault_IF   : instruction-access fault tag
//   o_valid_ID   : head beat valid toward decode
//   i_ready_ID   : decode takes the head beat
//   o_pc_ID      : head PC
//   o_pcplus4_ID : head PC+4
//   o_instr_ID   : head instruction
//   o_fault_ID   : head fault tag
//   o_bubble_cnt : saturating count of starved decode cycles
module if_id_elastic
  import osiris_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = NOP_INSTR_DEFAULT,
  parameter int unsigned           CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_flush_ID,
  input  logic                  i_valid_IF,
  output logic                  o_ready_IF,
  input  logic [DATA_WIDTH-1:0] i_pc_IF,
  input  logic [DATA_WIDTH-1:0] i_pcplus4_IF,
  input  logic [DATA_WIDTH-1:0] i_instr_IF,
  input  logic                  i_fault_IF,
  output logic                  o_valid_ID,
  input  logic                  i_ready_ID,
  output logic [DATA_WIDTH-1:0] o_pc_ID,
  output logic [DATA_WIDTH-1:0] o_pcplus4_ID,
  output logic [DATA_WIDTH-1:0] o_instr_ID,
  output logic                  o_fault_ID,
  output logic [CNT_WIDTH-1:0]  o_bubble_cnt
);

  // Payload layout matches if_id_beat_t: pc, pcplus4, instr, fault (MSB first).
  localparam int unsigned PAYLOAD_W = 3 * DATA_WIDTH + 1;

  localparam logic [PAYLOAD_W-1:0] BUBBLE_PAYLOAD =
    {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}}, NOP_INSTR, 1'b0};

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [PAYLOAD_W-1:0] push_data;
  logic [PAYLOAD_W-1:0] pop_data;
  logic [CNT_WIDTH-1:0] bubble_cnt_reg;
  logic                 starved;

  assign push_data = {i_pc_IF, i_pcplus4_IF, i_instr_IF, i_fault_IF};
  assign {o_pc_ID, o_pcplus4_ID, o_instr_ID, o_fault_ID} = pop_data;

  skid_buffer #(
    .WIDTH  (PAYLOAD_W),
    .BUBBLE (BUBBLE_PAYLOAD)
  ) u_skid (
    .clk        (clk),
    .rst        (i_rst),
    .flush      (i_flush_ID),
    .push_valid (i_valid_IF),
    .push_ready (o_ready_IF),
    .push_data  (push_data),
    .pop_valid  (o_valid_ID),
    .pop_ready  (i_ready_ID),
    .pop_data   (pop_data)
  );

  // A flush cycle is a deliberate redirect, not starvation, so it is not
  // counted even though decode sees no valid beat.
  assign starved = i_ready_ID & ~o_valid_ID & ~i_flush_ID;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      bubble_cnt_reg <= '0;
    end else if (starved && (bubble_cnt_reg != CNT_MAX)) begin
      bubble_cnt_reg <= bubble_cnt_reg + CNT_ONE;
    end
  end

  assign o_bubble_cnt = bubble_cnt_reg;

endmodule
